// File: rtl/fast_window.sv
// rtl/fast_window.sv - 7x7 sliding window that emits a 16-pixel Bresenham circle for FAST
//
// Purpose: buffers the last six image lines and builds a 7x7 pixel window over a
// raster-order grayscale stream. For every interior window centre it emits the
// 16-pixel radius-3 circle and the centre pixel. The output layout matches the
// FAST_9 i_circle/i_center ports.
//
// Ports:
//   i_clk     - clock; all state updates on the rising edge
//   i_rst_n   - asynchronous active-low reset
//   i_valid   - i_pixel is accepted on this edge (there is no backpressure)
//   i_sof     - qualified by i_valid; the pixel is position (0,0) of a new frame
//   i_pixel   - 8-bit grayscale pixel in raster order
//   o_valid   - one-cycle strobe; o_circle/o_center/o_col/o_row are valid
//   o_circle  - circle pixel[i] = o_circle[8i+7:8i], clockwise from the top
//   o_center  - window centre pixel
//   o_col     - centre column
//   o_row     - centre row
module fast_window #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  input  logic         i_sof,
  input  logic [7:0]   i_pixel,
  output logic         o_valid,
  output logic [127:0] o_circle,
  output logic [7:0]   o_center,
  output logic [15:0]  o_col,
  output logic [15:0]  o_row
);

  localparam int          CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [15:0] COL_LAST = 16'(IMG_W - 1);
  localparam logic [15:0] ROW_LAST = 16'(IMG_H - 1);

  // col/row hold the position the next accepted pixel will take.
  logic [15:0]   col;
  logic [15:0]   row;
  logic [15:0]   cur_col;
  logic [15:0]   cur_row;
  logic [CW-1:0] cidx;
  logic          emit;

  // Line buffers: lb[0] holds line r-6 (oldest), lb[5] holds line r-1.
  logic [7:0] lb      [0:5][0:IMG_W-1];
  // Window: win[y][x], x=6 is the newest column, y=6 is the newest line.
  logic [7:0] win     [0:6][0:6];
  logic [7:0] win_nxt [0:6][0:6];
  logic [127:0] circle_nxt;

  // A start-of-frame pixel takes position (0,0) no matter what the counters hold.
  assign cur_col = i_sof ? 16'd0 : col;
  assign cur_row = i_sof ? 16'd0 : row;
  assign cidx    = cur_col[CW-1:0];

  // Counting restarts inside each frame, so a centre is interior (and the whole
  // window belongs to the current frame and line) once c >= 6 and r >= 6.
  assign emit = i_valid && (cur_col >= 16'd6) && (cur_row >= 16'd6);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col <= '0;
      row <= '0;
    end else if (i_valid) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? 16'd0 : cur_row + 16'd1;
      end else begin
        col <= cur_col + 16'd1;
        row <= cur_row;
      end
    end
  end

  // Each column slot ripples upward one line: read-before-write at the same index.
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      for (int k = 0; k < 5; k++) begin
        lb[k][cidx] <= lb[k+1][cidx];
      end
      lb[5][cidx] <= i_pixel;
    end
  end

  always_comb begin
    for (int y = 0; y < 7; y++) begin
      for (int x = 0; x < 6; x++) begin
        win_nxt[y][x] = win[y][x+1];
      end
    end
    for (int y = 0; y < 6; y++) begin
      win_nxt[y][6] = lb[y][cidx];
    end
    win_nxt[6][6] = i_pixel;
  end

  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      win <= win_nxt;
    end
  end

  // Circle pixel i at offset (dx,dy) sits at win[3+dy][3+dx]; pixel 15 is the MSB.
  assign circle_nxt = {win_nxt[0][2], win_nxt[1][1], win_nxt[2][0], win_nxt[3][0],
                       win_nxt[4][0], win_nxt[5][1], win_nxt[6][2], win_nxt[6][3],
                       win_nxt[6][4], win_nxt[5][5], win_nxt[4][6], win_nxt[3][6],
                       win_nxt[2][6], win_nxt[1][5], win_nxt[0][4], win_nxt[0][3]};

  // Outputs are captured from the window including the pixel being accepted,
  // so the strobe is high in the cycle right after the accepting edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid  <= 1'b0;
      o_circle <= '0;
      o_center <= '0;
      o_col    <= '0;
      o_row    <= '0;
    end else begin
      o_valid <= emit;
      if (emit) begin
        o_circle <= circle_nxt;
        o_center <= win_nxt[3][3];
        o_col    <= cur_col - 16'd3;
        o_row    <= cur_row - 16'd3;
      end
    end
  end

endmodule

// File: doc/fast_window.md
FAST_WINDOW -- requirements
Module: FAST_window

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- IMG_W, 640, pixels per line (>= 8).
- IMG_H, 480, lines per frame (>= 8).

REQ-002 Ports, one per line: name, direction, width, meaning.
- i_clk, in, 1, single clock; all state on rising edge.
- i_rst_n, in, 1, reset; asynchronous, active-low.
- i_valid, in, 1, i_pixel is accepted on this edge.
- i_sof, in, 1, qualified by i_valid; marks the first pixel of a frame.
- i_pixel, in, 8, grayscale pixel in raster order.
- o_valid, out, 1, one-cycle strobe; o_circle/o_center/o_col/o_row are valid.
- o_circle, out, 128, flattened 16-pixel Bresenham circle; pixel[i] = o_circle[8i+7:8i].
- o_center, out, 8, window centre pixel.
- o_col, out, 16, centre column.
- o_row, out, 16, centre row.

Function
REQ-003 No backpressure: every pixel is accepted on each edge where i_valid=1, with no stall signal.
REQ-004 Input position counters (col, row) track each accepted pixel's raster position.
- col increments per accepted pixel; at IMG_W-1 it wraps to 0 and row increments.
- row wraps from IMG_H-1 to 0.
REQ-005 i_sof=1 with i_valid=1 forces that pixel's position to (0,0); later counting continues from there.
REQ-006 i_sof with i_valid=0 is ignored.
REQ-007 Six line buffers, each IMG_W x 8 bits, hold the previous six lines.
- Buffers are read and written at index col on each accepted pixel.
- Buffers are not reset.
REQ-008 A 7x7 window shifts one column left per accepted pixel.
- The new right column, top to bottom, is the six line-buffer reads (oldest line first) followed by i_pixel.
- The window holds its contents when i_valid=0.
REQ-009 The window centre is position (c-3, r-3), where (c, r) is the position of the newest accepted pixel.
REQ-010 Circle offsets (dx, dy), y increasing downward, clockwise from the top:
- 0:(0,-3) 1:(1,-3) 2:(2,-2) 3:(3,-1) 4:(3,0) 5:(3,1) 6:(2,2) 7:(1,3)
- 8:(0,3) 9:(-1,3) 10:(-2,2) 11:(-3,1) 12:(-3,0) 13:(-3,-1) 14:(-2,-2) 15:(-1,-3)
REQ-011 o_valid asserts only for accepted pixels with c >= 6 and r >= 6.
- Only interior centres are emitted: cols 3..IMG_W-4, rows 3..IMG_H-4.
- No output spans a line wrap or a frame wrap.
REQ-012 Latency: outputs register on the edge after the accepting edge, so o_valid is high in the cycle after that edge and lasts exactly one cycle.
REQ-013 o_col = c-3 and o_row = r-3, taken from the pixel that completed the window.
REQ-014 o_circle, o_center, o_col and o_row hold their last values while o_valid=0.
REQ-015 Gaps in i_valid of any length, including gaps across line ends, do not corrupt the window or the line buffers.
REQ-016 After i_sof, o_valid stays low until 6 full lines plus 7 pixels of the new frame have been accepted.
- This holds even if the previous frame was truncated.
REQ-017 o_circle is bit-compatible with the FAST_9 i_circle port, and o_center with i_center.
- A FAST_9 instance may be connected directly.
- The downstream flag/score then arrives 5 cycles after o_valid.

Reset
REQ-018 i_rst_n low asynchronously clears:
- col and row counters;
- the o_valid register;
- o_circle, o_center, o_col, o_row (all to 0).
REQ-019 Reset does not clear window registers or line-buffer contents.
- After reset, o_valid stays 0 until 6 lines plus 7 pixels have been accepted.
REQ-020 Reset asserted mid-frame:
- o_valid drops in the same cycle;
- the first pixel after release is position (0,0), whether or not i_sof is set.

Verification (IMG_W=16, IMG_H=12)
REQ-021 Frame with pixel(x,y) = 16*y + x, i_valid held high:
- exactly 10x6 = 60 o_valid strobes occur;
- the first strobe has o_col=3, o_row=3, o_center=0x33, pixel[0]=0x03, pixel[4]=0x36, pixel[12]=0x30.
REQ-022 Same frame with i_valid toggling 1,0,0,1 in a random pattern:
- strobe count is 60;
- output values match REQ-021 in order.
REQ-023 Two back-to-back frames, second frame pixels XOR 0xFF:
- 120 strobes in total;
- no strobe carries mixed-frame data;
- second frame's first strobe has o_center=0xCC.
REQ-024 i_sof asserted at input position (5,7) of frame 1:
- counters resync, so that pixel counts as (0,0);
- the next strobe has o_col=3, o_row=3, and follows 6*16+7 accepted pixels.
REQ-025 i_rst_n pulsed low at input position (8,8):
- o_valid=0 and o_circle=0 in the same cycle;
- the restarted frame produces 60 correct strobes.
REQ-026 Connect FAST_9 downstream:
- inject a 9-arc brighter corner at centre (7,5);
- o_keypoints_flag=1 appears exactly 5 cycles after that o_valid.
